// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite bus encodings and slave FSM states
package ahb_pkg;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_t;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD} hsize_t;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_byte_ram.sv
// ahb_byte_ram: 32-bit word RAM with byte-lane writes, async read and sync clear
module ahb_byte_ram #(
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // clear every word on reset, otherwise merge the enabled byte lanes
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else
      for (int b = 0; b < 4; b++) if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory slave with programmable wait states and two-cycle ERROR
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] a_idx;
  logic [1:0] a_off;
  logic a_write;
  logic [2:0] a_size;
  logic open, take, bad, we;
  logic [3:0] be;
  logic [31:0] rdata;
  logic unused;
  assign unused = htrans[0];
  assign open = state inside {ST_IDLE, ST_DONE, ST_ERR2};
  assign take = open & hsel & hready & htrans[1];
  assign bad = 32'(haddr[ADDR_WIDTH-1:2]) >= MEM_DEPTH || hsize > SZ_WORD ||
               (hsize == SZ_HALF && haddr[0]) || (hsize == SZ_WORD && haddr[1:0] != 2'd0);
  // next state: IDLE/DONE/ERR2 can take a new transfer, WAIT counts down, ERR1 always moves to ERR2
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      ST_WAIT: begin
        cnt_n = cnt - 4'd1;
        state_n = cnt == 4'd1 ? ST_DONE : ST_WAIT;
      end
      ST_ERR1: state_n = ST_ERR2;
      default: begin
        state_n = !take ? ST_IDLE : bad ? ST_ERR1 : WAIT_STATES == 0 ? ST_DONE : ST_WAIT;
        cnt_n = take && !bad ? 4'(WAIT_STATES) : 4'd0;
      end
    endcase
  end
  // state and wait counter registers
  always_ff @(posedge hclk)
    if (hreset) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // address-phase capture of the accepted transfer
  always_ff @(posedge hclk)
    if (take) begin
      a_idx <= haddr[AW+1:2];
      a_off <= haddr[1:0];
      a_write <= hwrite;
      a_size <= hsize;
    end
  assign be = a_size == SZ_BYTE ? 4'b0001 << a_off :
              a_size == SZ_HALF ? (a_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign we = state == ST_DONE && a_write && !hreset;
  ahb_byte_ram #(.DEPTH(MEM_DEPTH)) u_ram (
    .clk(hclk),
    .rst(hreset),
    .addr(a_idx),
    .be(we ? be : 4'b0000),
    .wdata(hwdata),
    .rdata(rdata)
  );
  assign hreadyout = !(state == ST_WAIT || state == ST_ERR1);
  assign hresp = state inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata = state == ST_DONE && !a_write ? rdata : '0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: two slaves (1 and 0 wait states) checked against a transfer-level model
module tb_ahb_slave_mem;
  logic hclk = 0, hreset = 1, hready = 1, hwrite = 0, stall = 0;
  logic [1:0] hsel = 0, htrans = 0;
  logic [9:0] haddr = 0;
  logic [2:0] hsize = 0;
  logic [31:0] hwdata = 0, ap_wdata = 0, rd0, rd1;
  logic [1:0] rdy, rsp;
  int total = 0, bad = 0;
  bit live = 0;
  logic [31:0] m [2][128];
  bit dv [2], de [2], dw [2];
  int age [2], len [2], didx [2], doff [2], dsz [2], errcyc [2], lowcyc [2];
  logic [31:0] dwd [2];
  logic [31:0] rdq [2][$];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(rdy[0]), .hresp(rsp[0]), .hrdata(rd0)
  );
  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(rdy[1]), .hresp(rsp[1]), .hrdata(rd1)
  );

  function automatic int ws(int k); return k == 0 ? 1 : 0; endfunction
  function automatic bit last(int k); return dv[k] && age[k] == len[k] - 1; endfunction
  function automatic bit e_rdy(int k); return !dv[k] || last(k); endfunction
  function automatic bit e_rsp(int k); return dv[k] && de[k]; endfunction
  function automatic bit is_rd(int k); return last(k) && !de[k] && !dw[k]; endfunction
  function automatic logic [31:0] e_rd(int k); return is_rd(k) ? m[k][didx[k]] : 32'd0; endfunction
  function automatic bit lane(int sz, int off, int b);
    int lo = sz == 2 ? 0 : sz == 1 ? (off & 2) : off;
    return b >= lo && b < lo + (1 << sz);
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // transfer-level model: a data phase lasts WS+1 cycles (OKAY) or 2 (ERROR); writes land on its last edge
  always @(posedge hclk)
    for (int k = 0; k < 2; k++)
      if (hreset) begin
        dv[k] = 0;
        for (int i = 0; i < 128; i++) m[k][i] = 0;
      end else begin
        if (last(k)) begin
          if (!de[k] && dw[k])
            for (int b = 0; b < 4; b++)
              if (lane(dsz[k], doff[k], b)) m[k][didx[k]][8*b +: 8] = dwd[k][8*b +: 8];
          dv[k] = 0;
        end else if (dv[k]) age[k]++;
        if (!dv[k] && hsel[k] && hready && htrans[1]) begin
          didx[k] = int'(haddr) >> 2;
          doff[k] = int'(haddr) & 3;
          dsz[k] = int'(hsize);
          dw[k] = hwrite;
          dwd[k] = ap_wdata;
          de[k] = didx[k] >= 128 || hsize > 2 || (hsize == 1 && haddr[0]) || (hsize == 2 && doff[k] != 0);
          len[k] = de[k] ? 2 : ws(k) + 1;
          age[k] = 0;
          dv[k] = 1;
        end
      end

  // compare every cycle, away from the active edge
  always @(negedge hclk)
    if (live)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("hreadyout%0d", k), 32'(rdy[k]), 32'(e_rdy(k)));
        chk($sformatf("hresp%0d", k), 32'(rsp[k]), 32'(e_rsp(k)));
        chk($sformatf("hrdata%0d", k), k == 0 ? rd0 : rd1, e_rd(k));
        if (is_rd(k)) rdq[k].push_back(k == 0 ? rd0 : rd1);
        if (rsp[k]) errcyc[k]++;
        if (!rdy[k]) lowcyc[k]++;
      end

  task automatic step();
    @(posedge hclk);
    #1;
    hready = e_rdy(0) && e_rdy(1) && !stall;
    for (int k = 0; k < 2; k++) if (dv[k] && dw[k]) hwdata = dwd[k];
  endtask

  task automatic issue(int k, logic [1:0] tr, logic wr, logic [9:0] a, logic [2:0] sz, logic [31:0] wd);
    bit ok;
    int n = 0;
    hsel = 2'b01 << k;
    htrans = tr;
    hwrite = wr;
    haddr = a;
    hsize = sz;
    ap_wdata = wd;
    do begin
      ok = hready;
      step();
      n++;
    end while (!ok && n < 40);
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(int n);
    hsel = 0;
    htrans = 0;
    repeat (n) step();
  endtask

  initial begin
    int e0, l0;
    repeat (2) step();
    hreset = 0;
    live = 1;
    issue(0, 2'b10, 1, 10'h004, 3'd2, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 10'h004, 3'd2, 32'h0);
    idle(3);
    chk("rd_deadbeef", rdq[0][$], 32'hDEADBEEF);
    chk("ws1_low_cycles", 32'(lowcyc[0]), 32'd2);
    issue(0, 2'b10, 1, 10'h006, 3'd0, 32'h55AA5555);
    issue(0, 2'b10, 0, 10'h004, 3'd2, 32'h0);
    idle(3);
    chk("rd_byte_lane2", rdq[0][$], 32'hDEAABEEF);
    e0 = errcyc[0];
    issue(0, 2'b10, 0, 10'h200, 3'd2, 32'h0);
    idle(3);
    chk("err_oob_cycles", 32'(errcyc[0] - e0), 32'd2);
    issue(0, 2'b10, 0, 10'h004, 3'd2, 32'h0);
    idle(3);
    chk("rd_after_oob", rdq[0][$], 32'hDEAABEEF);
    e0 = errcyc[0];
    issue(0, 2'b10, 1, 10'h001, 3'd1, 32'hFFFFFFFF);
    idle(3);
    chk("err_half_cycles", 32'(errcyc[0] - e0), 32'd2);
    issue(0, 2'b10, 0, 10'h000, 3'd2, 32'h0);
    idle(3);
    chk("rd_after_half_err", rdq[0][$], 32'h0);
    issue(1, 2'b10, 1, 10'h000, 3'd2, 32'h11111111);
    issue(1, 2'b10, 1, 10'h004, 3'd2, 32'h22222222);
    issue(1, 2'b10, 1, 10'h008, 3'd2, 32'h33333333);
    issue(1, 2'b10, 0, 10'h000, 3'd2, 32'h0);
    issue(1, 2'b11, 0, 10'h004, 3'd2, 32'h0);
    issue(1, 2'b11, 0, 10'h008, 3'd2, 32'h0);
    idle(2);
    chk("ws0_low_cycles", 32'(lowcyc[1]), 32'd0);
    chk("ws0_reads", 32'(rdq[1].size()), 32'd3);
    if (rdq[1].size() == 3) begin
      chk("ws0_rd0", rdq[1][0], 32'h11111111);
      chk("ws0_rd1", rdq[1][1], 32'h22222222);
      chk("ws0_rd2", rdq[1][2], 32'h33333333);
    end
    issue(0, 2'b10, 1, 10'h010, 3'd2, 32'h12345678);
    hsel = 0;
    htrans = 0;
    hreset = 1;
    step();
    hreset = 0;
    step();
    chk("after_reset_ready", 32'(rdy[0]), 32'd1);
    issue(0, 2'b10, 0, 10'h010, 3'd2, 32'h0);
    idle(3);
    chk("rd_after_reset", rdq[0][$], 32'h0);
    l0 = lowcyc[0];
    stall = 1;
    hready = 0;
    hsel = 2'b01;
    htrans = 2'b10;
    hwrite = 1;
    haddr = 10'h004;
    hsize = 3'd2;
    repeat (3) step();
    stall = 0;
    idle(2);
    chk("stall_no_accept", 32'(lowcyc[0] - l0), 32'd0);
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 1);
      logic [9:0] a = $urandom_range(0, 9) == 0 ? 10'($urandom) : 10'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      logic [2:0] sz = $urandom_range(0, 7) > 5 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (sz == 3'd1) a[0] = $urandom_range(0, 5) == 0;
      if (sz == 3'd2 && $urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      issue(k, 2'($urandom_range(0, 3)), 1'($urandom), a, sz, $urandom);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
